// File: rtl/key_scan.sv
// -----------------------------------------------------------------------------
// key_scan -- 4x4 matrix keypad scanner with debounce.
//
// One column at a time is driven low. The synchronized row lines are sampled
// once per scan tick. A non-idle row pattern must stay unchanged for
// DEBOUNCE_CNT further ticks before the key is accepted. Release needs
// DEBOUNCE_CNT further all-high ticks before scanning resumes.
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat.
//   With the macro, a held key re-strobes key_valid after REPEAT_DELAY ticks
//   and then every REPEAT_RATE ticks.
//   Without the macro, no repeat logic exists and both repeat parameters are
//   ignored.
//
// Ports:
//   clk100mhz  in   1  system clock (only clock)
//   reset      in   1  asynchronous active-high reset
//   row        in   4  keypad rows, active-low, externally pulled up
//   col        out  4  column drive, active-low one-hot
//   key_code   out  4  last accepted key, col_index*4 + row_index
//   key_valid  out  1  one-cycle strobe per accepted press (and per repeat)
//   key_held   out  1  high while the accepted key is still pressed
// -----------------------------------------------------------------------------
module key_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clk100mhz,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic [3:0]       r_col;
  logic [3:0]       r_pattern;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_tick;
  logic             w_all_high;
  logic [3:0]       w_col_rot;
  state_t           w_state_nxt;
  logic [3:0]       w_col_nxt;
  logic [3:0]       w_pattern_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_key_code_nxt;
  logic             w_key_valid_nxt;
  logic             w_key_held_nxt;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  // r_rep counts hold ticks since the last strobe.
  // r_rep_first selects whether the initial delay or the repeat rate applies.
  logic [REP_W-1:0] r_rep;
  logic             r_rep_first;
  logic [REP_W-1:0] w_rep_nxt;
  logic             w_rep_first_nxt;
  logic [REP_W-1:0] w_rep_last;

  assign w_rep_last = r_rep_first ? REP_DELAY_LAST : REP_RATE_LAST;
`else
  // Repeat timing parameters have no effect in this build.
  if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_repeat_unused
  end
`endif

  // Column index of the active-low one-hot column drive.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Lowest-numbered low row wins when several rows are pressed together.
  function automatic logic [1:0] row_index(input logic [3:0] p);
    logic [1:0] idx;
    if (!p[0]) begin
      idx = 2'd0;
    end else if (!p[1]) begin
      idx = 2'd1;
    end else if (!p[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  assign w_tick     = (r_div == DIV_LAST);
  assign w_all_high = (r_row_sync == 4'b1111);
  assign w_col_rot  = {r_col[2:0], r_col[3]};

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
    end
  end

  // Scan-tick divider: w_tick is high for one cycle every SCAN_DIV cycles.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      r_div <= {DIV_W{1'b0}};
    end else if (w_tick) begin
      r_div <= {DIV_W{1'b0}};
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Next-state and next-output logic.
  // Nothing changes outside tick cycles, except that key_valid drops back to 0.
  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_pattern_nxt   = r_pattern;
    w_cnt_nxt       = r_cnt;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
`ifdef KEY_REPEAT_EN
    w_rep_nxt       = r_rep;
    w_rep_first_nxt = r_rep_first;
`endif
    if (w_tick) begin
      case (r_state)
        S_SCAN: begin
          if (w_all_high) begin
            w_col_nxt = w_col_rot;
          end else begin
            w_pattern_nxt = r_row_sync;
            w_cnt_nxt     = {CNT_W{1'b0}};
            w_state_nxt   = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (r_row_sync != r_pattern) begin
            w_state_nxt = S_SCAN;
          end else if (r_cnt == DEB_LAST) begin
            w_key_code_nxt  = {col_index(r_col), row_index(r_pattern)};
            w_key_valid_nxt = 1'b1;
            w_key_held_nxt  = 1'b1;
            w_state_nxt     = S_PRESSED;
`ifdef KEY_REPEAT_EN
            w_rep_nxt       = {REP_W{1'b0}};
            w_rep_first_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          if (w_all_high) begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = S_RELEASE;
          end else begin
`ifdef KEY_REPEAT_EN
            if (r_rep == w_rep_last) begin
              w_key_valid_nxt = 1'b1;
              w_rep_nxt       = {REP_W{1'b0}};
              w_rep_first_nxt = 1'b0;
            end else begin
              w_rep_nxt = r_rep + 1'b1;
            end
`else
            w_state_nxt = S_PRESSED;
`endif
          end
        end
        S_RELEASE: begin
          if (!w_all_high) begin
            w_state_nxt = S_PRESSED;
`ifdef KEY_REPEAT_EN
            w_rep_nxt       = {REP_W{1'b0}};
            w_rep_first_nxt = 1'b1;
`endif
          end else if (r_cnt == DEB_LAST) begin
            w_key_held_nxt = 1'b0;
            w_col_nxt      = w_col_rot;
            w_state_nxt    = S_SCAN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_SCAN;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state, column drive, counters and registered outputs.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      r_state     <= S_SCAN;
      r_col       <= 4'b1110;
      r_pattern   <= 4'b1111;
      r_cnt       <= {CNT_W{1'b0}};
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep       <= {REP_W{1'b0}};
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_pattern   <= w_pattern_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
`ifdef KEY_REPEAT_EN
      r_rep       <= w_rep_nxt;
      r_rep_first <= w_rep_first_nxt;
`endif
    end
  end

endmodule
